share_encoder_prng: RTL and testbench

//   Upstream stage of the masked XOR gadget. Takes unmasked bits a and b, splits each into two

---
 rtl/share_encoder_prng_pkg.sv | 27 ++
 rtl/share_encoder_prng_if.sv | 32 +++
 rtl/share_encoder_prng_lfsr5.sv | 35 +++
 rtl/share_encoder_prng.sv | 106 ++++++++++
 tb/tb_share_encoder_prng.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/share_encoder_prng_pkg.sv
// Shared constants, FSM state type and the 5-step LFSR next-state function
// for the share encoder and its PRNG.
package share_encoder_prng_pkg;

    localparam int          LFSR_W_DEF   = 32;
    // Feedback taps: bits 31, 21, 1, 0
    localparam logic [31:0] LFSR_TAPS    = 32'h8020_0003;
    localparam logic [31:0] SEED_DEF     = 32'hACE1_2BAD;
    localparam int          WARMUP_DEF   = 16;

    typedef enum logic {
        ST_WARMUP = 1'b0,
        ST_RUN    = 1'b1
    } state_t;

    // Five single-bit shifts; the newest bit lands in s[0], so after the
    // call s[4:0] holds the five fresh bits (s[0] the last one produced).
    function automatic logic [31:0] lfsr_step5(input logic [31:0] s);
        logic [31:0] t;
        t = s;
        for (int i = 0; i < 5; i++) begin
            t = {t[30:0], ^(t & LFSR_TAPS)};
        end
        return t;
    endfunction

endpackage

// File: rtl/share_encoder_prng_if.sv
// Handshake bundle between the upstream producer, the share encoder and the
// downstream XOR gadget.
interface share_encoder_prng_if;

    // Both sides use valid/ready: a beat transfers on a rising clk edge where
    // valid && ready; valid never depends on ready and the payload stays
    // stable while valid && !ready.
    logic in_valid;
    logic in_ready;
    logic a;
    logic b;
    logic out_valid;
    logic out_ready;
    logic A0;
    logic A1;
    logic B0;
    logic B1;
    logic r0;
    logic r1;
    logic r2;

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, A0, A1, B0, B1, r0, r1, r2
    );

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, A0, A1, B0, B1, r0, r1, r2
    );

endinterface

// File: rtl/share_encoder_prng_lfsr5.sv
// Seeded 32-bit Fibonacci LFSR advancing five steps per enabled clock; the
// next five fresh bits are offered combinationally to the share encoder.
module share_encoder_prng_lfsr5
    import share_encoder_prng_pkg::*;
#(
    parameter logic [31:0] SEED_RST = SEED_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] seed,
    input  logic        adv,
    output logic [4:0]  bits,
    output logic [31:0] state
);

    logic [31:0] s;
    logic [31:0] s_next;

    assign s_next = lfsr_step5(s);
    assign bits   = s_next[4:0];
    assign state  = s;

    // An all-zero state would lock the LFSR, so a zero seed falls back to the default.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s <= SEED_RST;
        end else if (load) begin
            s <= (seed == 32'h0) ? SEED_RST : seed;
        end else if (adv) begin
            s <= s_next;
        end
    end

endmodule

// File: rtl/share_encoder_prng.sv
// Splits unmasked bits a and b into Boolean shares with fresh LFSR masks and
// emits them, with gadget refresh bits r0..r2, from one registered stage.
module share_encoder_prng
    import share_encoder_prng_pkg::*;
#(
    parameter int                LFSR_W       = LFSR_W_DEF,
    parameter logic [LFSR_W-1:0] DEFAULT_SEED = SEED_DEF,
    parameter int                WARMUP       = WARMUP_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 seed_load,
    input  logic [LFSR_W-1:0]    seed_in,
    share_encoder_prng_if.slave  bus,
    output logic                 busy,
    output state_t               dbg_state,
    output logic [LFSR_W-1:0]    dbg_lfsr
);

    localparam int CNT_W = $clog2(WARMUP) + 1;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             out_valid;
    logic             in_ready;
    logic             accept;
    logic             adv;
    logic [4:0]       fresh;
    logic             a0_q, a1_q, b0_q, b1_q, r0_q, r1_q, r2_q;

    assign in_ready = (state == ST_RUN) && (!out_valid || bus.out_ready);
    // A reseed in the same cycle wins; the offered input is left untaken.
    assign accept   = bus.in_valid && in_ready && !seed_load;
    assign adv      = (state == ST_WARMUP) || accept;

    share_encoder_prng_lfsr5 #(
        .SEED_RST (DEFAULT_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (seed_load),
        .seed  (seed_in),
        .adv   (adv),
        .bits  (fresh),
        .state (dbg_lfsr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_WARMUP;
            cnt       <= '0;
            out_valid <= 1'b0;
            a0_q      <= 1'b0;
            a1_q      <= 1'b0;
            b0_q      <= 1'b0;
            b1_q      <= 1'b0;
            r0_q      <= 1'b0;
            r1_q      <= 1'b0;
            r2_q      <= 1'b0;
        end else if (seed_load) begin
            state     <= ST_WARMUP;
            cnt       <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_WARMUP: begin
                    if (cnt == CNT_W'(WARMUP - 1)) begin
                        state <= ST_RUN;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase

            if (accept) begin
                out_valid <= 1'b1;
                a0_q      <= bus.a ^ fresh[0];
                a1_q      <= fresh[0];
                b0_q      <= bus.b ^ fresh[1];
                b1_q      <= fresh[1];
                r0_q      <= fresh[2];
                r1_q      <= fresh[3];
                r2_q      <= fresh[4];
            end else if (out_valid && bus.out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.A0        = a0_q;
    assign bus.A1        = a1_q;
    assign bus.B0        = b0_q;
    assign bus.B1        = b1_q;
    assign bus.r0        = r0_q;
    assign bus.r1        = r1_q;
    assign bus.r2        = r2_q;
    assign busy          = (state == ST_WARMUP);
    assign dbg_state     = state;

endmodule

// File: tb/tb_share_encoder_prng.sv
// Directed bench for share_encoder_prng: reset/warm-up, streaming, backpressure,
// reseeding, a randomised handshake phase and an asynchronous reset mid-stream.
module tb_share_encoder_prng;
    import share_encoder_prng_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        seed_load;
    logic [31:0] seed_in;
    logic        busy;
    state_t      dbg_state;
    logic [31:0] dbg_lfsr;

    share_encoder_prng_if bus ();

    share_encoder_prng dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seed_load (seed_load),
        .seed_in   (seed_in),
        .bus       (bus),
        .busy      (busy),
        .dbg_state (dbg_state),
        .dbg_lfsr  (dbg_lfsr)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_assert = 0;
    int         n_fail   = 0;
    logic [31:0] m_s;
    logic [6:0]  first_vec;
    logic [6:0]  last_vec;
    logic [6:0]  exp_q[$];

    // Reference LFSR written bit by bit from the tap equation.
    function automatic logic [31:0] model_step5(input logic [31:0] s);
        logic [31:0] t;
        logic        fb;
        t = s;
        for (int k = 0; k < 5; k++) begin
            fb = t[31] ^ t[21] ^ t[1] ^ t[0];
            t  = {t[30:0], fb};
        end
        return t;
    endfunction

    function automatic logic [6:0] beat_vec(input logic av, input logic bv, input logic [31:0] s);
        return {av ^ s[0], s[0], bv ^ s[1], s[1], s[2], s[3], s[4]};
    endfunction

    function automatic logic [6:0] dut_vec();
        return {bus.A0, bus.A1, bus.B0, bus.B1, bus.r0, bus.r1, bus.r2};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic warmup_from(input logic [31:0] seed);
        m_s = seed;
        for (int i = 0; i < 16; i++) begin
            chk("warm_in_ready", {31'b0, bus.in_ready}, 32'd0);
            chk("warm_busy", {31'b0, busy}, 32'd1);
            m_s = model_step5(m_s);
            cyc();
        end
        chk("warm_done_ready", {31'b0, bus.in_ready}, 32'd1);
        chk("warm_done_busy", {31'b0, busy}, 32'd0);
    endtask

    // Called just after an edge that should have accepted (av,bv).
    task automatic check_beat(input string tag, input logic av, input logic bv);
        m_s      = model_step5(m_s);
        last_vec = beat_vec(av, bv, m_s);
        chk({tag, "_valid"}, {31'b0, bus.out_valid}, 32'd1);
        chk({tag, "_vec"}, {25'b0, dut_vec()}, {25'b0, last_vec});
        chk({tag, "_shareA"}, {31'b0, bus.A0 ^ bus.A1}, {31'b0, av});
        chk({tag, "_shareB"}, {31'b0, bus.B0 ^ bus.B1}, {31'b0, bv});
    endtask

    initial begin
        logic pop;
        logic acc;
        logic rdy_exp;

        rst_n         = 1'b0;
        seed_load     = 1'b0;
        seed_in       = 32'h0;
        bus.in_valid  = 1'b1;
        bus.a         = 1'b0;
        bus.b         = 1'b0;
        bus.out_ready = 1'b1;

        // 1: reset and warm-up with in_valid held high
        repeat (3) cyc();
        chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst_outputs", {25'b0, dut_vec()}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd1);
        chk("rst_lfsr", dbg_lfsr, 32'hACE1_2BAD);
        rst_n = 1'b1;
        warmup_from(32'hACE1_2BAD);
        chk("pre_accept_outputs", {25'b0, dut_vec()}, 32'd0);
        chk("pre_accept_valid", {31'b0, bus.out_valid}, 32'd0);
        cyc();
        check_beat("first", 1'b0, 1'b0);
        first_vec = last_vec;

        // 2: stream all four (a,b) pairs at full rate
        for (int i = 0; i < 4000; i++) begin
            bus.a = i[1];
            bus.b = i[0];
            #1;
            chk("stream_ready", {31'b0, bus.in_ready}, 32'd1);
            cyc();
            check_beat("stream", i[1], i[0]);
        end

        // 3: backpressure holds outputs and the LFSR
        bus.out_ready = 1'b0;
        bus.a         = 1'b1;
        bus.b         = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_in_ready", {31'b0, bus.in_ready}, 32'd0);
            cyc();
            chk("bp_valid", {31'b0, bus.out_valid}, 32'd1);
            chk("bp_stable", {25'b0, dut_vec()}, {25'b0, last_vec});
            chk("bp_lfsr", dbg_lfsr, m_s);
        end
        bus.out_ready = 1'b1;
        cyc();
        check_beat("bp_release", 1'b1, 1'b1);

        // 4: zero seed falls back to the default while a beat is pending
        seed_load    = 1'b1;
        seed_in      = 32'h0;
        bus.in_valid = 1'b0;
        cyc();
        seed_load = 1'b0;
        chk("zseed_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("zseed_lfsr", dbg_lfsr, 32'hACE1_2BAD);
        warmup_from(32'hACE1_2BAD);
        bus.in_valid = 1'b1;
        bus.a        = 1'b0;
        bus.b        = 1'b0;
        cyc();
        check_beat("zseed_first", 1'b0, 1'b0);
        chk("zseed_eq_reset", {25'b0, dut_vec()}, {25'b0, first_vec});

        // 5: reseed beats a simultaneous input offer
        seed_load = 1'b1;
        seed_in   = 32'h0000_0001;
        bus.a     = 1'b1;
        bus.b     = 1'b0;
        cyc();
        seed_load = 1'b0;
        chk("reseed_not_accepted", {31'b0, bus.out_valid}, 32'd0);
        chk("reseed_lfsr", dbg_lfsr, 32'h0000_0001);
        warmup_from(32'h0000_0001);
        cyc();
        check_beat("reseed_first", 1'b1, 1'b0);

        // randomised handshake against the scoreboard
        exp_q.push_back(last_vec);
        for (int i = 0; i < 400; i++) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.a         = 1'($urandom_range(0, 1));
            bus.b         = 1'($urandom_range(0, 1));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            rdy_exp = (exp_q.size() == 0) || bus.out_ready;
            chk("rnd_in_ready", {31'b0, bus.in_ready}, {31'b0, rdy_exp});
            chk("rnd_out_valid", {31'b0, bus.out_valid}, {31'b0, (exp_q.size() != 0)});
            pop = (exp_q.size() != 0) && bus.out_ready;
            acc = bus.in_valid && rdy_exp;
            if (pop) begin
                chk("rnd_data", {25'b0, dut_vec()}, {25'b0, exp_q[0]});
                void'(exp_q.pop_front());
            end
            if (acc) begin
                m_s = model_step5(m_s);
                exp_q.push_back(beat_vec(bus.a, bus.b, m_s));
            end
            cyc();
        end

        // asynchronous reset in the middle of a cycle
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        cyc();
        chk("pre_rst_valid", {31'b0, bus.out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("async_rst_outputs", {25'b0, dut_vec()}, 32'd0);
        chk("async_rst_busy", {31'b0, busy}, 32'd1);
        chk("async_rst_ready", {31'b0, bus.in_ready}, 32'd0);
        cyc();
        rst_n = 1'b1;
        warmup_from(32'hACE1_2BAD);
        bus.a = 1'b0;
        bus.b = 1'b0;
        cyc();
        chk("post_rst_first", {25'b0, dut_vec()}, {25'b0, first_vec});

        // final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
